// File: rtl/pwr_pkg.sv
// Shared defaults and helpers for the activity counter bank.
package pwr_pkg;

    localparam int unsigned PWR_NCH_DEF = 4;
    localparam int unsigned PWR_CW_DEF  = 32;
    localparam int unsigned PWR_AW_DEF  = 2;
    localparam int unsigned PWR_MAX_CH  = 16;

    function automatic logic addr_in_range(input int unsigned addr, input int unsigned nch);
        return (addr < nch);
    endfunction

endpackage

// File: rtl/pwr_cntr_ch.sv
// One activity channel: toggle detect, counter, sticky overflow.
// Build option PWR_CNTR_SAT_EN: saturate at all-ones instead of wrapping.
module pwr_cntr_ch import pwr_pkg::*; #(
    parameter int CW = PWR_CW_DEF
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          iAct,
    input  logic          iEn,
    input  logic          iClr,
    input  logic          iWr,
    input  logic [CW-1:0] iDato,
    output logic [CW-1:0] oCnt,
    output logic          oOvf
);

    logic          r_prev;
    logic          r_armed;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;

    logic          w_toggle;
    logic          w_inc;
    logic          w_at_max;
    logic [CW-1:0] w_next;

    // The first sample after reset only primes r_prev.
    assign w_toggle = r_armed & (iAct ^ r_prev);
    assign w_inc    = iEn & w_toggle;
    assign w_at_max = &r_cnt;

`ifdef PWR_CNTR_SAT_EN
    assign w_next = w_at_max ? r_cnt : r_cnt + CW'(1);
`else
    assign w_next = r_cnt + CW'(1);
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_prev  <= iAct;
            r_armed <= 1'b1;
            // Priority: clear, then preset, then count.
            if (iClr) begin
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (iWr) begin
                r_cnt <= iDato;
            end else if (w_inc) begin
                r_cnt <= w_next;
                if (w_at_max) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign oCnt = r_cnt;
    assign oOvf = r_ovf;

endmodule

// File: rtl/pwr_cntr_bank.sv
// Bank of per-channel activity counters with addressed read/preset port.
// Saturating counters when PWR_CNTR_SAT_EN is defined (see pwr_cntr_ch).
module pwr_cntr_bank import pwr_pkg::*; #(
    parameter int NCH = PWR_NCH_DEF,
    parameter int CW  = PWR_CW_DEF,
    parameter int AW  = PWR_AW_DEF
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic [NCH-1:0] iAct,
    input  logic           iEn,
    input  logic           iClr,
    input  logic [AW-1:0]  iDir,
    input  logic           iRd,
    input  logic           iWr,
    input  logic [CW-1:0]  iDato,
    output logic [CW-1:0]  oDato,
    output logic           oValid,
    output logic [NCH-1:0] oOvf,
    output logic           oErr
);

    if (NCH < 1 || NCH > int'(PWR_MAX_CH) || (2 ** AW) < NCH) begin : g_bad_cfg
        $error("pwr_cntr_bank: unsupported NCH/AW combination");
    end

    logic [CW-1:0]  w_cnt [NCH];
    logic [NCH-1:0] w_wr_sel;
    logic [CW-1:0]  w_rd_mux;
    logic           w_in_range;

    logic [CW-1:0]  r_dato;
    logic           r_valid;
    logic           r_err;

    assign w_in_range = addr_in_range(int'(iDir), NCH);

    always_comb begin
        w_wr_sel = '0;
        w_rd_mux = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (iDir == AW'(i)) begin
                w_wr_sel[i] = iWr & w_in_range;
                w_rd_mux    = w_cnt[i];
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        pwr_cntr_ch #(.CW(CW)) u_ch (
            .CLK   (CLK),
            .RESET (RESET),
            .iAct  (iAct[k]),
            .iEn   (iEn),
            .iClr  (iClr),
            .iWr   (w_wr_sel[k]),
            .iDato (iDato),
            .oCnt  (w_cnt[k]),
            .oOvf  (oOvf[k])
        );
    end

    // Read data is the pre-edge counter value; a bad address zeroes it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_dato  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if ((iRd | iWr) & ~w_in_range) begin
                r_err  <= 1'b1;
                r_dato <= '0;
            end else if (iRd) begin
                r_dato  <= w_rd_mux;
                r_valid <= 1'b1;
            end
        end
    end

    assign oDato  = r_dato;
    assign oValid = r_valid;
    assign oErr   = r_err;

endmodule

// File: doc/pwr_cntr_bank.md
PWR_CNTR_BANK -- requirements
Module: pwr_cntr_bank

Interface
REQ-001 SHALL have parameter NCH, default 4, number of monitored activity channels (1..16).
REQ-002 SHALL have parameter CW, default 32, counter width in bits (8..32).
REQ-003 SHALL have parameter AW, default 2, address width; 2**AW >= NCH.
REQ-004 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port iAct  input  NCH  per-channel activity nets, sampled each CLK.
REQ-007 SHALL have port iEn  input  1  global count enable.
REQ-008 SHALL have port iClr  input  1  synchronous clear of all counters and overflow flags.
REQ-009 SHALL have port iDir  input  AW  channel address for read/write.
REQ-010 SHALL have port iRd  input  1  read request.
REQ-011 SHALL have port iWr  input  1  write (preset) request.
REQ-012 SHALL have port iDato  input  CW  preset value for write.
REQ-013 SHALL have port oDato  output  CW  read data.
REQ-014 SHALL have port oValid  output  1  read data valid strobe.
REQ-015 SHALL have port oOvf  output  NCH  sticky per-channel overflow flags.
REQ-016 SHALL have port oErr  output  1  address-out-of-range strobe.

Function
REQ-017 SHALL register iAct each cycle into a previous-sample register; a toggle on channel k is iAct[k] != prev[k].
REQ-018 SHALL increment counter k by 1 per cycle with a toggle on k while iEn=1; no increment when iEn=0, but prev still updates.
REQ-019 SHALL not count the first sample after RESET deassertion (prev loaded from iAct in that cycle, armed flag set).
REQ-020 SHALL set oOvf[k] when counter k increments at all-ones; flag stays set until iClr or RESET.
REQ-021 Read: iRd=1 in cycle n -> oDato=counter[iDir] value at start of cycle n, oValid=1 in cycle n+1 only (latency 1); oDato holds last value otherwise.
REQ-022 Read and increment of the same channel in one cycle SHALL return the pre-increment value; the increment is not lost.
REQ-023 Write: iWr=1 loads iDato into counter[iDir] at the clock edge; write beats a simultaneous toggle on that channel; oOvf unaffected.
REQ-024 iRd and iWr together to the same address SHALL return old value and load new value.
REQ-025 iClr SHALL zero all counters and oOvf in one cycle; iClr beats iWr and toggles in the same cycle.
REQ-026 iDir >= NCH with iRd or iWr SHALL produce oErr=1 in cycle n+1, oValid=0, oDato=0, no state change.

Reset
REQ-027 RESET SHALL asynchronously force counters=0, prev=0, armed=0, oOvf=0, oDato=0, oValid=0, oErr=0.
REQ-028 RESET asserted mid-read SHALL suppress the pending oValid.

Configuration
REQ-029 With PWR_CNTR_SAT_EN defined, counters SHALL saturate at 2**CW-1 (oOvf still set on first attempted overflow).
REQ-030 Without PWR_CNTR_SAT_EN, counters SHALL wrap modulo 2**CW to 0.

Structure
REQ-031 Package pwr_pkg SHALL hold default NCH/CW/AW constants and max-channel constant 16.
REQ-032 Per-channel logic (prev sample, counter, overflow, saturate/wrap) SHALL be sub-module pwr_cntr_ch, instantiated NCH times; the bank holds address decode and read mux.

Verification
REQ-033 Reset release, iAct=4'b0101 constant, iEn=1, 10 cycles -> all counters read 0.
REQ-034 iAct[2] toggles every cycle for 7 cycles, iEn=1, then iRd iDir=2 -> oDato=7, oValid=1 one cycle later.
REQ-035 CW=8, write 255 to ch1, one toggle -> SAT_EN: read 255, oOvf[1]=1; no SAT_EN: read 0, oOvf[1]=1.
REQ-036 Same cycle iClr=1, iWr=1 to ch0 with iDato=42, toggle on ch0 -> ch0 reads 0, oOvf=0.
REQ-037 NCH=3, iRd with iDir=3 -> oErr=1, oValid=0, oDato=0 next cycle.
REQ-038 RESET asserted between edges during counting at count 5 -> counters 0 immediately, oValid not asserted.
